// File: rtl/change_log_pkg.sv
// Shared constants and writer state encoding for the change-detect logger.
package change_log_pkg;
  localparam int CL_ADDR_LEN   = 10;
  localparam int CL_DATA_WIDTH = 32;
  localparam int CL_BLOCK_LEN  = 6;
  localparam int CL_DROP_W     = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } wr_state_e;
endpackage

// File: rtl/change_log_blkq.sv
// Completed-block queue: tracks the oldest undrained block (head) and the
// number of blocks awaiting drain (pending).
module change_log_blkq #(
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] push_index_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o,
  output logic             full_o,
  output logic             fill_o
);
  localparam int NUM_BLOCKS = 1 << IDX_W;
  localparam logic [IDX_W:0] LAST_FREE = (IDX_W+1)'(NUM_BLOCKS - 1);

  logic [IDX_W:0]   pend_q, pend_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic             pop_ok;

  assign pop_ok = pop_i && valid_o;

  always_comb begin
    pend_d = pend_q;
    head_d = head_q;
    if (push_i && !pop_ok)      pend_d = pend_q + 1'b1;
    else if (pop_ok && !push_i) pend_d = pend_q - 1'b1;
    // An empty queue adopts the pushed block as its oldest entry.
    if (pop_ok)                          head_d = head_q + 1'b1;
    else if (push_i && pend_q == '0)     head_d = push_index_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      head_q <= '0;
    end else begin
      pend_q <= pend_d;
      head_q <= head_d;
    end
  end

  assign valid_o = (pend_q != '0);
  assign index_o = head_q;
  // pending never exceeds NUM_BLOCKS, so the MSB alone marks a full queue.
  assign full_o  = pend_q[IDX_W];
  assign fill_o  = push_i && !pop_ok && (pend_q == LAST_FREE);
endmodule

// File: rtl/change_log_writer.sv
// Change-detect logger writing changed words to sequential memory addresses.
// Define CHANGE_LOG_DROP_CNT_EN to add the saturating DROP_CNT output.
module change_log_writer
  import change_log_pkg::*;
#(
  parameter int ADDR_LEN   = CL_ADDR_LEN,
  parameter int DATA_WIDTH = CL_DATA_WIDTH,
  parameter int BLOCK_LEN  = CL_BLOCK_LEN
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         IN,
  output logic [ADDR_LEN-1:0]           MEM_ADDR,
  output logic [DATA_WIDTH-1:0]         MEM_D,
  output logic                          MEM_WE,
  output logic                          BLK_VALID,
  output logic [ADDR_LEN-BLOCK_LEN-1:0] BLK_INDEX,
  input  logic                          BLK_READY,
  output logic                          STALL
`ifdef CHANGE_LOG_DROP_CNT_EN
  ,
  output logic [CL_DROP_W-1:0]          DROP_CNT
`endif
);
  localparam int IDX_W = ADDR_LEN - BLOCK_LEN;

  logic [DATA_WIDTH-1:0] d_in_q;
  logic [ADDR_LEN-1:0]   wr_ptr_q;
  logic [ADDR_LEN-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_d_q;
  logic                  mem_we_q;
  wr_state_e             state_q;

  logic                  change, push, pop, blk_full, blk_fill;
  logic [IDX_W-1:0]      push_idx;

  assign change   = (IN != d_in_q);
  // The write issued last cycle closes a block when it hit the block's last word.
  assign push     = mem_we_q && (&mem_addr_q[BLOCK_LEN-1:0]);
  assign push_idx = mem_addr_q[ADDR_LEN-1:BLOCK_LEN];
  assign pop      = BLK_READY && BLK_VALID;

  change_log_blkq #(.IDX_W(IDX_W)) u_blkq (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (push),
    .pop_i        (BLK_READY),
    .push_index_i (push_idx),
    .valid_o      (BLK_VALID),
    .index_o      (BLK_INDEX),
    .full_o       (blk_full),
    .fill_o       (blk_fill)
  );

  // A change arriving on the edge that fills the queue would land on the
  // oldest undrained block, so it is dropped as if already stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_in_q     <= '0;
      wr_ptr_q   <= '0;
      state_q    <= ST_RUN;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
    end else begin
      d_in_q   <= IN;
      mem_we_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (change && !blk_fill) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_ptr_q;
            mem_d_q    <= IN;
            wr_ptr_q   <= wr_ptr_q + 1'b1;
          end
          if (blk_fill) state_q <= ST_STALL;
        end
        ST_STALL: if (pop) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

`ifdef CHANGE_LOG_DROP_CNT_EN
  logic                 drop;
  logic [CL_DROP_W-1:0] drop_q;

  assign drop = change && ((state_q == ST_STALL) || blk_fill);

  always_ff @(posedge CLK) begin
    if (RST)                         drop_q <= '0;
    else if (drop && drop_q != '1)   drop_q <= drop_q + 1'b1;
  end

  assign DROP_CNT = drop_q;
`endif

  assign MEM_ADDR = mem_addr_q;
  assign MEM_D    = mem_d_q;
  assign MEM_WE   = mem_we_q;
  assign STALL    = (state_q == ST_STALL) && blk_full;
endmodule

// File: tb/tb_change_log_writer.sv
// Bench for change_log_writer: queue-based reference model, directed scenarios, random run.
module tb_change_log_writer;
  localparam int AL = 4, BL = 2, DW = 8;
  localparam int NB = 1 << (AL - BL), BS = 1 << BL, DEPTH = 1 << AL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          rdy = 1'b0;
  logic [AL-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic          mem_we, blk_valid, stall;
  logic [AL-BL-1:0] blk_index;
`ifdef CHANGE_LOG_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  change_log_writer #(.ADDR_LEN(AL), .DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .CLK(clk), .RST(rst), .IN(din),
    .MEM_ADDR(mem_addr), .MEM_D(mem_d), .MEM_WE(mem_we),
    .BLK_VALID(blk_valid), .BLK_INDEX(blk_index), .BLK_READY(rdy),
    .STALL(stall)
`ifdef CHANGE_LOG_DROP_CNT_EN
    , .DROP_CNT(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit chk_on = 1'b0;

  // Reference model: pending blocks are a FIFO of block indices.
  int m_prev, m_wptr, m_addr, m_d, m_drops;
  bit m_we;
  int m_q[$];

  function automatic void chk(input string n, input longint unsigned a, input longint unsigned e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  task automatic model_step();
    if (rst) begin
      m_prev = 0; m_wptr = 0; m_addr = 0; m_d = 0; m_drops = 0; m_we = 0;
      m_q.delete();
    end else begin
      bit completing, popping, full_now, about_full, nwe;
      int done_blk;
      completing = m_we && (m_addr % BS == BS - 1);
      done_blk   = m_addr / BS;
      popping    = (m_q.size() != 0) && rdy;
      full_now   = (m_q.size() == NB);
      about_full = completing && !popping && (m_q.size() == NB - 1);
      nwe = 0;
      if (int'(din) != m_prev) begin
        if (full_now || about_full) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_addr = m_wptr; m_d = din; nwe = 1;
          m_wptr = (m_wptr + 1) % DEPTH;
        end
      end
      if (popping) void'(m_q.pop_front());
      if (completing) m_q.push_back(done_blk);
      m_we = nwe;
      m_prev = din;
    end
  endtask

  task automatic tick(input int v, input bit r, input bit rs);
    din = v[DW-1:0]; rdy = r; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("MEM_WE", mem_we, m_we);
      if (m_we) begin
        chk("MEM_ADDR", mem_addr, m_addr);
        chk("MEM_D", mem_d, m_d);
      end
      chk("BLK_VALID", blk_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("BLK_INDEX", blk_index, m_q[0]);
      chk("STALL", stall, m_q.size() == NB);
`ifdef CHANGE_LOG_DROP_CNT_EN
      chk("DROP_CNT", drop_cnt, m_drops);
`endif
    end
  end

  initial begin
    int wr_cnt, p, v;
    bit r, rs;
    int hs[$];

    // Reset values
    tick(0, 0, 1); chk_on = 1'b1; tick(0, 0, 1);
    chk("rst MEM_WE", mem_we, 0); chk("rst MEM_ADDR", mem_addr, 0);
    chk("rst MEM_D", mem_d, 0);   chk("rst BLK_VALID", blk_valid, 0);
    chk("rst BLK_INDEX", blk_index, 0); chk("rst STALL", stall, 0);

    // Held value written once
    tick(5, 0, 0);
    chk("hold WE", mem_we, 1); chk("hold ADDR", mem_addr, 0); chk("hold D", mem_d, 5);
    wr_cnt = 1;
    for (int i = 0; i < 2; i++) begin tick(5, 0, 0); if (mem_we) wr_cnt++; end
    chk("hold writes", wr_cnt, 1);

    // First block completion
    tick(0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(i, 0, 0);
      chk("seq ADDR", mem_addr, i - 1);
    end
    chk("seq VALID early", blk_valid, 0);
    tick(4, 0, 0);
    chk("seq VALID", blk_valid, 1); chk("seq INDEX", blk_index, 0);

    // Fill all blocks, drop, then free one
    tick(0, 0, 1);
    for (int i = 1; i <= 16; i++) tick(i, 0, 0);
    tick(17, 0, 0);
    chk("full STALL", stall, 1); chk("full WE", mem_we, 0);
`ifdef CHANGE_LOG_DROP_CNT_EN
    chk("full DROP_CNT", drop_cnt, 1);
`endif
    tick(17, 1, 0);
    chk("free INDEX", blk_index, 1); chk("free STALL", stall, 0);
    tick(18, 0, 0);
    chk("free WE", mem_we, 1); chk("free ADDR", mem_addr, 0);

    // Completion and handshake on the same edge
    tick(0, 0, 1);
    for (int i = 1; i <= 8; i++) tick(i, 0, 0);
    tick(8, 1, 0);
    chk("simul VALID", blk_valid, 1); chk("simul INDEX", blk_index, 1);
    tick(8, 0, 0);
    chk("simul INDEX2", blk_index, 1);

    // Continuous drain across address wrap
    tick(0, 0, 1);
    wr_cnt = 0; hs.delete();
    for (int i = 0; i < 68; i++) begin
      if (blk_valid) hs.push_back(int'(blk_index));
      tick(i < 64 ? i + 1 : 64, 1, 0);
      if (mem_we) wr_cnt++;
    end
    chk("wrap writes", wr_cnt, 64);
    chk("wrap handshakes", hs.size(), 16);
    for (int i = 0; i < hs.size(); i++) chk("wrap hs index", hs[i], i % 4);
    chk("wrap drops", m_drops, 0);

    // Reset mid-operation
    tick(0, 0, 1);
    for (int i = 1; i <= 9; i++) tick(i, 0, 0);
    tick(9, 0, 0);
    chk("mid VALID", blk_valid, 1);
    tick(9, 0, 1);
    chk("mid rst VALID", blk_valid, 0); chk("mid rst STALL", stall, 0);
    tick(77, 0, 0);
    chk("mid WE", mem_we, 1); chk("mid ADDR", mem_addr, 0);

    // Randomized run with varying drain pressure
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0: p = 10;
        1: p = 50;
        default: p = 90;
      endcase
      for (int c = 0; c < 300; c++) begin
        v  = ($urandom_range(0, 99) < 70) ? int'($urandom_range(0, 255)) : int'(din);
        r  = ($urandom_range(0, 99) < p);
        rs = ($urandom_range(0, 399) == 0);
        tick(v, r, rs);
      end
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
